// File: rtl/key_click_if.sv
// Bundle between the key debouncer side and the click counter:
// a press strobe in, gesture reports and activity status out.
interface key_click_if #(
    parameter int CNT_W = 2
);
    // Strobe-only protocol, no back-pressure: key_pressed_stb_i is a one-cycle press
    // event and is always accepted; clicks_valid_o is a one-cycle report that the consumer
    // must take on that cycle, with clicks_cnt_o holding the count until the next report.
    logic             key_pressed_stb_i;
    logic             clicks_valid_o;
    logic [CNT_W-1:0] clicks_cnt_o;
    logic             busy_o;

    modport master (
        output key_pressed_stb_i,
        input  clicks_valid_o,
        input  clicks_cnt_o,
        input  busy_o
    );

    modport slave (
        input  key_pressed_stb_i,
        output clicks_valid_o,
        output clicks_cnt_o,
        output busy_o
    );
endinterface

// File: rtl/key_click_counter.sv
// Groups debounced key presses into multi-click gestures and reports the
// click count once the inactivity window closes or MAX_CLICKS is reached.
module key_click_counter #(
    parameter int CLK_FREQ_MHZ   = 100,
    parameter int WINDOW_TIME_US = 250,
    parameter int MAX_CLICKS     = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    key_click_if.slave  bus
);
    localparam int WINDOW_CYCLES = CLK_FREQ_MHZ * WINDOW_TIME_US;
    localparam int CNT_W         = $clog2(MAX_CLICKS + 1);
    localparam int TIMER_W       = $clog2(WINDOW_CYCLES);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
    logic [CNT_W-1:0]   count_inc;

    assign count_inc = count_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timer_d   = timer_q;
        valid_d   = 1'b0;
        cnt_out_d = cnt_out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.key_pressed_stb_i) begin
                    count_d = CNT_ONE;
                    timer_d = '0;
                    if (MAX_CLICKS == 1) begin
                        valid_d   = 1'b1;
                        cnt_out_d = CNT_ONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A strobe on the expiry cycle wins: it is counted and restarts the window.
                if (bus.key_pressed_stb_i) begin
                    count_d = count_inc;
                    timer_d = '0;
                    if (count_inc == CNT_MAX) begin
                        valid_d   = 1'b1;
                        cnt_out_d = count_inc;
                        state_d   = ST_IDLE;
                    end
                end else if (timer_q != TIMER_LAST) begin
                    timer_d = timer_q + 1'b1;
                end else begin
                    valid_d   = 1'b1;
                    cnt_out_d = count_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            cnt_out_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign bus.clicks_valid_o = valid_q;
    assign bus.clicks_cnt_o   = cnt_out_q;
    assign bus.busy_o         = (state_q == ST_WAIT);
endmodule
